nn_output_layer: RTL and testbench

NN_OUTPUT_LAYER -- requirements
Module: nn_output_layer

---
 rtl/nn_output_layer.sv | 147 ++++++++++++++
 tb/tb_nn_output_layer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_output_layer.sv
// Sequential fully-connected output layer: one MAC per cycle, bias + saturating ReLU per neuron.
// Optional argmax output class_idx is enabled by defining NN_OUT_ARGMAX_EN.
module nn_output_layer #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int FRAC  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req,
  input  logic signed [8*N_IN-1:0]               x,
  input  logic                                   wr_en,
  input  logic [((N_OUT*(N_IN+1)) > 1 ? $clog2(N_OUT*(N_IN+1)) : 1)-1:0] wr_addr,
  input  logic signed [7:0]                      wr_data,
  output logic                                   ack_layer,
  output logic signed [8*N_OUT-1:0]              y,
`ifdef NN_OUT_ARGMAX_EN
  output logic [(N_OUT > 1 ? $clog2(N_OUT) : 1)-1:0] class_idx,
`endif
  output logic                                   busy
);

  localparam int DEPTH = N_OUT * (N_IN + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

  state_t                  state;
  logic signed [7:0]       tbl [DEPTH];
  logic [8*N_IN-1:0]       x_q;
  logic signed [15:0]      acc;
  logic [IW-1:0]           i_q;
  logic [JW-1:0]           j_q;

  logic [AW-1:0]           base_addr, w_addr, b_addr;
  logic signed [7:0]       w_cur, b_cur, x_cur;
  logic signed [15:0]      prod;
  logic signed [16:0]      sum;
  logic [7:0]              res;
  logic                    i_last, j_last;

  assign busy = (state != IDLE);

  // Weight/bias table: never reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (int'(wr_addr) < DEPTH))
      tbl[wr_addr] <= wr_data;
  end

  always_comb begin
    base_addr = AW'(int'(j_q) * (N_IN + 1));
    w_addr    = base_addr + AW'(i_q);
    b_addr    = base_addr + AW'(N_IN);
    w_cur     = tbl[w_addr];
    b_cur     = tbl[b_addr];
    x_cur     = x_q[8*i_q +: 8];
    prod      = w_cur * x_cur;
    sum       = {acc[15], acc} + {{9{b_cur[7]}}, b_cur};
    i_last    = (i_q == IW'(N_IN - 1));
    j_last    = (j_q == JW'(N_OUT - 1));
    // Saturation to -128 followed by ReLU collapses to "any negative sum gives 0".
    if (sum < 17'sd0)
      res = '0;
    else if (sum > 17'sd127)
      res = 8'd127;
    else
      res = sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ack_layer <= 1'b0;
      y         <= '0;
      acc       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      x_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            x_q   <= x;
            acc   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + (prod >>> FRAC);
          if (i_last)
            state <= BIAS;
          else
            i_q <= i_q + 1'b1;
        end
        BIAS: begin
          y[8*j_q +: 8] <= res;
          if (!j_last) begin
            j_q   <= j_q + 1'b1;
            i_q   <= '0;
            acc   <= '0;
            state <= MAC;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          // Ack is raised one cycle after entry, then held until req is seen low.
          if (!ack_layer)
            ack_layer <= 1'b1;
          else if (!req) begin
            ack_layer <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NN_OUT_ARGMAX_EN
  logic [JW-1:0]     best_idx;
  logic signed [7:0] best_val;

  always_comb begin
    best_idx = '0;
    best_val = y[7:0];
    for (int unsigned k = 1; k < N_OUT; k++) begin
      if ($signed(y[8*k +: 8]) > best_val) begin
        best_val = y[8*k +: 8];
        best_idx = JW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      class_idx <= '0;
    else if (state == DONE && !ack_layer)
      class_idx <= best_idx;
  end
`endif

endmodule

// File: tb/tb_nn_output_layer.sv
// Self-checking bench for nn_output_layer against an integer-arithmetic reference model.
module tb_nn_output_layer;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int FRAC  = 4;
  localparam int DEPTH = N_OUT * (N_IN + 1);
  localparam int AW    = 3;
  localparam int LAT   = N_OUT * (N_IN + 1) + 1;
  localparam int BOUND = 40;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req = 1'b0;
  logic                wr_en = 1'b0;
  logic [8*N_IN-1:0]   x = '0;
  logic [AW-1:0]       wr_addr = '0;
  logic [7:0]          wr_data = '0;
  logic                ack_layer;
  logic                busy;
  logic [8*N_OUT-1:0]  y;
`ifdef NN_OUT_ARGMAX_EN
  logic [0:0]          class_idx;
`endif

  int errors = 0;
  int checks = 0;
  int tw [DEPTH];

  nn_output_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .req(req), .x(x),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ack_layer(ack_layer), .y(y),
`ifdef NN_OUT_ARGMAX_EN
    .class_idx(class_idx),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8*N_OUT-1:0] model_y(input logic [8*N_IN-1:0] xin);
    logic [8*N_OUT-1:0] r;
    logic signed [7:0]  xb;
    int acc, s;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        xb  = xin[8*i +: 8];
        acc = acc + ((tw[j*(N_IN+1)+i] * int'(xb)) >>> FRAC);
      end
      s = acc + tw[j*(N_IN+1)+N_IN];
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      if (s < 0)    s = 0;
      r[8*j +: 8] = 8'(s);
    end
    return r;
  endfunction

  function automatic int model_argmax(input logic [8*N_OUT-1:0] yv);
    int best;
    logic signed [7:0] a, b;
    best = 0;
    for (int k = 1; k < N_OUT; k++) begin
      a = yv[8*k +: 8];
      b = yv[8*best +: 8];
      if (a > b) best = k;
    end
    return best;
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic write_word(input int addr, input int data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = 8'(data);
    if (addr < DEPTH) tw[addr] = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_neuron(input int j, input int w0, input int w1, input int b);
    write_word(j*(N_IN+1) + 0, w0);
    write_word(j*(N_IN+1) + 1, w1);
    write_word(j*(N_IN+1) + 2, b);
  endtask

  // Raises req with xin, scrambles x after capture, returns edges until ack.
  task automatic run(input logic [8*N_IN-1:0] xin, output int lat);
    @(negedge clk);
    x   = xin;
    req = 1'b1;
    @(posedge clk); #1;
    x   = 16'($urandom);
    lat = 0;
    while (ack_layer !== 1'b1 && lat < BOUND) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack_layer !== 1'b0 || busy !== 1'b0 || y !== '0) begin
      errors++;
      $display("FAIL reset_state: ack=%b busy=%b y=%h, expected 0 0 0000", ack_layer, busy, y);
    end
`ifdef NN_OUT_ARGMAX_EN
    checks++;
    if (class_idx !== 1'b0) begin
      errors++;
      $display("FAIL reset_class_idx: got %0d expected 0", class_idx);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] exp_y;
    set_neuron(0, 16, 16, 0);
    set_neuron(1, 16, -16, 8);
    exp_y = model_y({8'd16, 8'd32});
    run({8'd16, 8'd32}, lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges expected %0d", lat, LAT);
    end
    checks++;
    if (y !== 16'h1830) begin
      errors++;
      $display("FAIL basic_y_const: got %h expected 1830", y);
    end
    checks++;
    if (y !== exp_y) begin
      errors++;
      $display("FAIL basic_y_model: got %h expected %h", y, exp_y);
    end
`ifdef NN_OUT_ARGMAX_EN
    checks++;
    if (class_idx !== 1'b0) begin
      errors++;
      $display("FAIL basic_class_idx: got %0d expected 0", class_idx);
    end
`endif
    release_req();
    checks++;
    if (ack_layer !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: ack=%b busy=%b expected 0 0", ack_layer, busy);
    end
  endtask

  task automatic test_relu();
    int lat;
    set_neuron(0, -16, 0, 0);
    run({8'd0, 8'd32}, lat);
    checks++;
    if (y[7:0] !== 8'd0 || y !== model_y({8'd0, 8'd32})) begin
      errors++;
      $display("FAIL relu_y: got %h expected %h", y, model_y({8'd0, 8'd32}));
    end
    release_req();
  endtask

  task automatic test_saturation();
    int lat;
    set_neuron(0, 127, 127, 127);
    run({8'd127, 8'd127}, lat);
    checks++;
    if (y[7:0] !== 8'd127) begin
      errors++;
      $display("FAIL sat_pos: got %0d expected 127", y[7:0]);
    end
    release_req();
    set_neuron(0, -128, -128, 0);
    run({8'd127, 8'd127}, lat);
    checks++;
    if (y[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL sat_neg_relu: got %0d expected 0", y[7:0]);
    end
    release_req();
  endtask

  task automatic test_handshake();
    int lat;
    int bad;
    logic [15:0] exp_y;
    set_neuron(0, 16, 16, 0);
    exp_y = model_y({8'd16, 8'd32});
    run({8'd16, 8'd32}, lat);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      x = 16'($urandom);
      @(posedge clk); #1;
      if (ack_layer !== 1'b1 || busy !== 1'b1 || y !== exp_y) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_req_no_restart: %0d bad cycles, expected 0 (y=%h want %h)", bad, y, exp_y);
    end
    release_req();
    checks++;
    if (ack_layer !== 1'b0) begin
      errors++;
      $display("FAIL ack_fall: got %b expected 0", ack_layer);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] exp_y;
    exp_y = model_y({8'd16, 8'd32});
    @(negedge clk);
    x   = {8'd16, 8'd32};
    req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || y !== '0 || ack_layer !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b y=%h ack=%b expected 0 0000 0", busy, y, ack_layer);
    end
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run({8'd16, 8'd32}, lat);
    checks++;
    if (y !== exp_y || lat !== LAT) begin
      errors++;
      $display("FAIL reset_rerun: y=%h lat=%0d expected %h %0d", y, lat, exp_y, LAT);
    end
    release_req();
  endtask

  task automatic test_write_guard();
    int lat;
    logic [15:0] exp_y;
    exp_y = model_y({8'd16, 8'd32});
    @(negedge clk);
    x   = {8'd16, 8'd32};
    req = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = '0; wr_data = '0;
    @(posedge clk); #1;
    wr_en = 1'b0;
    lat = 0;
    while (ack_layer !== 1'b1 && lat < BOUND) begin @(posedge clk); #1; lat++; end
    checks++;
    if (y !== exp_y) begin
      errors++;
      $display("FAIL guard_current: got %h expected %h", y, exp_y);
    end
    release_req();
    run({8'd16, 8'd32}, lat);
    checks++;
    if (y !== exp_y) begin
      errors++;
      $display("FAIL guard_next: got %h expected %h", y, exp_y);
    end
    release_req();
    set_neuron(0, 16, 16, 0);
    set_neuron(1, 16, 16, 0);
    run({8'd16, 8'd24}, lat);
    checks++;
    if (y !== 16'h2828) begin
      errors++;
      $display("FAIL tie_y: got %h expected 2828", y);
    end
`ifdef NN_OUT_ARGMAX_EN
    checks++;
    if (class_idx !== 1'b0) begin
      errors++;
      $display("FAIL tie_class_idx: got %0d expected 0", class_idx);
    end
`endif
    release_req();
  endtask

  task automatic test_addr_guard();
    int lat;
    logic [15:0] xin;
    for (int a = DEPTH; a < (1 << AW); a++) write_word(a, rnd8());
    xin = 16'($urandom);
    run(xin, lat);
    checks++;
    if (y !== model_y(xin)) begin
      errors++;
      $display("FAIL addr_guard: got %h expected %h", y, model_y(xin));
    end
    release_req();
  endtask

  task automatic test_same_cycle();
    int lat;
    int nb;
    logic [15:0] xin;
    nb  = rnd8();
    xin = 16'($urandom);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(N_IN); wr_data = 8'(nb);
    tw[N_IN] = nb;
    x = xin; req = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    lat = 0;
    while (ack_layer !== 1'b1 && lat < BOUND) begin @(posedge clk); #1; lat++; end
    checks++;
    if (y !== model_y(xin)) begin
      errors++;
      $display("FAIL same_cycle_write: got %h expected %h", y, model_y(xin));
    end
    release_req();
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] xin, exp_y;
    for (int n = 0; n < 12; n++) begin
      for (int a = 0; a < DEPTH; a++) write_word(a, rnd8());
      xin   = 16'($urandom);
      exp_y = model_y(xin);
      run(xin, lat);
      checks++;
      if (y !== exp_y || lat !== LAT) begin
        errors++;
        $display("FAIL random_%0d: y=%h lat=%0d expected %h %0d", n, y, lat, exp_y, LAT);
      end
`ifdef NN_OUT_ARGMAX_EN
      checks++;
      if (int'(class_idx) != model_argmax(exp_y)) begin
        errors++;
        $display("FAIL random_class_%0d: got %0d expected %0d", n, class_idx, model_argmax(exp_y));
      end
`endif
      release_req();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_handshake();
    set_neuron(0, 16, 16, 0);
    set_neuron(1, 16, -16, 8);
    test_reset_mid();
    test_write_guard();
    test_addr_guard();
    test_same_cycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
